// File: rtl/register_bank.sv
// register_bank: 32x32 MIPS register file with $0 hardwired to zero,
// programmable $sp reset value and two registered, write-through read ports.
module register_bank #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter logic [DATA_W-1:0] SP_INIT = 227,
  parameter int                SP_IDX  = 29
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ReadEn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              RdValid
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] reg_q [NREG];
  logic [DATA_W-1:0] reg_d [NREG];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              vld_q, vld_d;
  logic              wr_en;

  assign wr_en = RegWrite && (WriteReg != '0);

  // next register contents: apply this cycle's write, $0 never written
  always_comb begin
    reg_d = reg_q;
    if (wr_en) begin
      reg_d[WriteReg] = WriteData;
    end
  end

  // read ports sample the post-write view so a same-edge write bypasses
  always_comb begin
    rd1_d = rd1_q;
    rd2_d = rd2_q;
    vld_d = 1'b0;
    if (ReadEn) begin
      vld_d = 1'b1;
      rd1_d = (ReadReg1 == '0) ? '0 : reg_d[ReadReg1];
      rd2_d = (ReadReg2 == '0) ? '0 : reg_d[ReadReg2];
    end
  end

  // state update; reset overrides writes and in-flight reads
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
      rd1_q <= '0;
      rd2_q <= '0;
      vld_q <= 1'b0;
    end else begin
      reg_q <= reg_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      vld_q <= vld_d;
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign RdValid   = vld_q;

endmodule
